// File: rtl/id_scroll_disp.sv
// Scrolling hexadecimal ID display controller for a multiplexed,
// common-anode 7-segment board display. Shows an N_AN-digit window of an
// N_NIB-nibble ID, scanning one digit at a time and scrolling the window
// one nibble per step period.
module id_scroll_disp #(
  parameter int unsigned        N_NIB    = 16,
  parameter logic [N_NIB*4-1:0] ID       = 64'h1135_1127_0081_5f18,
  parameter int unsigned        N_AN     = 8,
  parameter int unsigned        SCAN_DIV = 100_000,
  parameter int unsigned        STEP_DIV = 100_000_000
) (
  input  logic                       clk100M,
  input  logic                       sys_rst,
  input  logic                       run,
  input  logic                       U_D,
  input  logic                       home,
  input  logic                       dp_in,
  output logic                       CA,
  output logic                       CB,
  output logic                       CC,
  output logic                       CD,
  output logic                       CE,
  output logic                       CF,
  output logic                       CG,
  output logic                       DP,
  output logic [N_AN-1:0]            AN,
  output logic [$clog2(N_NIB)-1:0]   pos
);

  localparam int unsigned POS_W  = $clog2(N_NIB);
  localparam int unsigned IDX_W  = (N_AN > 1) ? $clog2(N_AN) : 1;
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned STEP_W = $clog2(STEP_DIV);
  // Wide enough for pos + N_AN-1 without overflow before the modulo.
  localparam int unsigned SUM_W  = $clog2(N_NIB + N_AN) + 1;

  logic [SCAN_W-1:0] scan_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic              scan_tick;
  logic              step_tick;
  logic [SUM_W-1:0]  nib_sum;
  logic [SUM_W-1:0]  nib_idx;
  logic [3:0]        nib_val;
  logic [6:0]        seg_q;

  // Active-low {CA..CG} pattern for one hex digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign step_tick = (step_cnt == STEP_W'(STEP_DIV - 1));

  // Digit scan divider.
  always_ff @(posedge clk100M or posedge sys_rst) begin
    if (sys_rst)        scan_cnt <= '0;
    else if (scan_tick) scan_cnt <= '0;
    else                scan_cnt <= scan_cnt + SCAN_W'(1);
  end

  // Free-running scroll step divider.
  always_ff @(posedge clk100M or posedge sys_rst) begin
    if (sys_rst)        step_cnt <= '0;
    else if (step_tick) step_cnt <= '0;
    else                step_cnt <= step_cnt + STEP_W'(1);
  end

  // Active digit index, advancing once per scan period.
  always_ff @(posedge clk100M or posedge sys_rst) begin
    if (sys_rst) begin
      scan_idx <= '0;
    end else if (scan_tick) begin
      if (scan_idx == IDX_W'(N_AN - 1)) scan_idx <= '0;
      else                              scan_idx <= scan_idx + IDX_W'(1);
    end
  end

  // Window position: home wins over a step; wrap by compare so any N_NIB works.
  always_ff @(posedge clk100M or posedge sys_rst) begin
    if (sys_rst) begin
      pos <= '0;
    end else if (home) begin
      pos <= '0;
    end else if (step_tick && run) begin
      if (U_D) pos <= (pos == POS_W'(N_NIB - 1)) ? '0 : pos + POS_W'(1);
      else     pos <= (pos == '0) ? POS_W'(N_NIB - 1) : pos - POS_W'(1);
    end
  end

  // Nibble shown on the active digit: (pos + N_AN-1-scan_idx) mod N_NIB.
  always_comb begin
    nib_sum = SUM_W'(pos) + SUM_W'(N_AN - 1) - SUM_W'(scan_idx);
    nib_idx = nib_sum % SUM_W'(N_NIB);
    nib_val = 4'h0;
    for (int i = 0; i < N_NIB; i++) begin
      if (nib_idx == SUM_W'(i)) nib_val = ID[(N_NIB-1-i)*4 +: 4];
    end
  end

  // Registered segment, decimal point and anode drive.
  always_ff @(posedge clk100M or posedge sys_rst) begin
    if (sys_rst) begin
      seg_q <= '1;
      DP    <= 1'b1;
      AN    <= '1;
    end else begin
      seg_q <= seg_decode(nib_val);
      DP    <= dp_in;
      AN    <= ~(N_AN'(1) << scan_idx);
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;

endmodule

// File: tb/tb_id_scroll_disp.sv
// Bench for id_scroll_disp: directed vector table for the documented
// scenarios plus randomized stimulus against a cycle-level reference model.
module tb_id_scroll_disp;

  localparam int SCAN = 4;
  localparam int STEP = 64;
  localparam int NAN  = 8;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  localparam int ID16 [16] = '{1,1,3,5,1,1,2,7,0,0,8,1,5,15,1,8};

  logic clk;
  logic sys_rst, run, U_D, home, dp_in;

  logic ca16, cb16, cc16, cd16, ce16, cf16, cg16, dp16;
  logic ca10, cb10, cc10, cd10, ce10, cf10, cg10, dp10;
  logic [7:0] an16, an10;
  logic [3:0] pos16, pos10;
  logic [6:0] s16, s10;

  assign s16 = {ca16, cb16, cc16, cd16, ce16, cf16, cg16};
  assign s10 = {ca10, cb10, cc10, cd10, ce10, cf10, cg10};

  id_scroll_disp #(.N_NIB(16), .N_AN(NAN), .SCAN_DIV(SCAN), .STEP_DIV(STEP)) dut16 (
    .clk100M(clk), .sys_rst(sys_rst), .run(run), .U_D(U_D), .home(home), .dp_in(dp_in),
    .CA(ca16), .CB(cb16), .CC(cc16), .CD(cd16), .CE(ce16), .CF(cf16), .CG(cg16),
    .DP(dp16), .AN(an16), .pos(pos16));

  id_scroll_disp #(.N_NIB(10), .ID(40'h0123456789), .N_AN(NAN), .SCAN_DIV(SCAN),
                   .STEP_DIV(STEP)) dut10 (
    .clk100M(clk), .sys_rst(sys_rst), .run(run), .U_D(U_D), .home(home), .dp_in(dp_in),
    .CA(ca10), .CB(cb10), .CC(cc10), .CD(cd10), .CE(ce10), .CF(cf10), .CG(cg10),
    .DP(dp10), .AN(an10), .pos(pos10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int n_edges;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n_edges++;
  endtask

  // Reference model: cycles since reset decide scan digit and step ticks.
  int         m_cyc, m_p16, m_p10, m_d;
  logic [7:0] m_an;
  logic [6:0] m_s16, m_s10;
  logic       m_dp;

  always @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_cyc = 0; m_p16 = 0; m_p10 = 0;
      m_an = 8'hFF; m_s16 = 7'h7F; m_s10 = 7'h7F; m_dp = 1'b1;
    end else begin
      m_d   = (m_cyc / SCAN) % NAN;
      m_an  = ~(8'(1) << m_d);
      m_s16 = SEG_TAB[ID16[(m_p16 + NAN - 1 - m_d) % 16]];
      m_s10 = SEG_TAB[(m_p10 + NAN - 1 - m_d) % 10];
      m_dp  = dp_in;
      if (home) begin
        m_p16 = 0; m_p10 = 0;
      end else if (run && (m_cyc % STEP == STEP - 1)) begin
        if (U_D) begin m_p16 = (m_p16 + 1) % 16;  m_p10 = (m_p10 + 1) % 10; end
        else     begin m_p16 = (m_p16 + 15) % 16; m_p10 = (m_p10 + 9) % 10; end
      end
      m_cyc++;
    end
  end

  typedef struct {
    int         edge_no;
    logic       run;
    logic       ud;
    logic       home;
    logic [7:0] an;
    logic [6:0] s16;
    logic [6:0] s10;
    int         p16;
    int         p10;
  } vec_t;

  vec_t vt [16];

  initial begin
    // edge_no counts clock edges after reset release, starting at 0.
    vt[0]  = '{0,    0, 1, 0, 8'hFE, 7'h0F, 7'h0F, 0,  0};
    vt[1]  = '{4,    0, 1, 0, 8'hFD, 7'h12, 7'h20, 0,  0};
    vt[2]  = '{28,   0, 1, 0, 8'h7F, 7'h4F, 7'h01, 0,  0};
    vt[3]  = '{32,   0, 1, 0, 8'hFE, 7'h0F, 7'h0F, 0,  0};
    vt[4]  = '{63,   1, 1, 0, 8'h7F, 7'h4F, 7'h01, 1,  1};
    vt[5]  = '{64,   1, 1, 0, 8'hFE, 7'h01, 7'h00, 1,  1};
    vt[6]  = '{1023, 1, 1, 0, 8'h7F, 7'h00, 7'h24, 0,  6};
    vt[7]  = '{1087, 1, 0, 0, 8'h7F, 7'h4F, 7'h20, 15, 5};
    vt[8]  = '{1088, 1, 0, 0, 8'hFE, 7'h12, 7'h12, 15, 5};
    vt[9]  = '{1116, 1, 0, 0, 8'h7F, 7'h00, 7'h24, 15, 5};
    vt[10] = '{1151, 1, 0, 1, 8'h7F, 7'h00, 7'h24, 0,  0};
    vt[11] = '{1152, 1, 0, 0, 8'hFE, 7'h0F, 7'h0F, 0,  0};
    vt[12] = '{1215, 1, 1, 0, 8'h7F, 7'h4F, 7'h01, 1,  1};
    vt[13] = '{1407, 0, 1, 0, 8'h7F, 7'h4F, 7'h4F, 1,  1};
    vt[14] = '{1919, 1, 1, 0, 8'h7F, 7'h01, 7'h00, 9,  9};
    vt[15] = '{1983, 1, 1, 0, 8'h7F, 7'h01, 7'h04, 10, 0};

    sys_rst = 1'b1; run = 1'b0; U_D = 1'b1; home = 1'b0; dp_in = 1'b1;
    n_edges = 0;
    repeat (3) @(negedge clk);
    chk("rst_an16", 32'(an16), 32'hFF);
    chk("rst_seg16", 32'(s16), 32'h7F);
    chk("rst_dp16", 32'(dp16), 32'h1);
    chk("rst_pos16", 32'(pos16), 32'h0);
    chk("rst_an10", 32'(an10), 32'hFF);
    chk("rst_pos10", 32'(pos10), 32'h0);

    sys_rst = 1'b0;
    n_edges = 0;

    for (int i = 0; i < 16; i++) begin
      int guard;
      run = vt[i].run;
      U_D = vt[i].ud;
      guard = 0;
      while (n_edges < vt[i].edge_no && guard < 5000) begin
        tick();
        guard++;
      end
      if (n_edges != vt[i].edge_no) begin
        errs++; checks++;
        $display("FAIL vec%0d_timeout: edges %0d want %0d", i, n_edges, vt[i].edge_no);
      end
      home = vt[i].home;
      tick();
      home = 1'b0;
      chk($sformatf("vec%0d_an16", i), 32'(an16), 32'(vt[i].an));
      chk($sformatf("vec%0d_seg16", i), 32'(s16), 32'(vt[i].s16));
      chk($sformatf("vec%0d_pos16", i), 32'(pos16), 32'(vt[i].p16));
      chk($sformatf("vec%0d_an10", i), 32'(an10), 32'(vt[i].an));
      chk($sformatf("vec%0d_seg10", i), 32'(s10), 32'(vt[i].s10));
      chk($sformatf("vec%0d_pos10", i), 32'(pos10), 32'(vt[i].p10));
    end

    // Reset asserted mid-digit takes effect without waiting for a clock.
    tick(); tick();
    sys_rst = 1'b1;
    #2;
    chk("midrst_an16", 32'(an16), 32'hFF);
    chk("midrst_seg16", 32'(s16), 32'h7F);
    chk("midrst_dp16", 32'(dp16), 32'h1);
    chk("midrst_pos16", 32'(pos16), 32'h0);
    chk("midrst_an10", 32'(an10), 32'hFF);
    chk("midrst_pos10", 32'(pos10), 32'h0);
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    n_edges = 0;
    tick();
    chk("restart_an16", 32'(an16), 32'hFE);
    chk("restart_seg16", 32'(s16), 32'h0F);
    chk("restart_an10", 32'(an10), 32'hFE);
    tick(); tick(); tick();
    chk("hold4_an16", 32'(an16), 32'hFE);
    tick();
    chk("next_an16", 32'(an16), 32'hFD);

    // Decimal point follows dp_in one cycle later.
    dp_in = 1'b0;
    tick();
    chk("dp_low16", 32'(dp16), 32'h0);
    chk("dp_low10", 32'(dp10), 32'h0);
    dp_in = 1'b1;
    tick();
    chk("dp_high16", 32'(dp16), 32'h1);

    // Randomized stimulus against the reference model.
    run = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      chk("rnd_an16", 32'(an16), 32'(m_an));
      chk("rnd_seg16", 32'(s16), 32'(m_s16));
      chk("rnd_dp16", 32'(dp16), 32'(m_dp));
      chk("rnd_pos16", 32'(pos16), 32'(m_p16));
      chk("rnd_an10", 32'(an10), 32'(m_an));
      chk("rnd_seg10", 32'(s10), 32'(m_s10));
      chk("rnd_dp10", 32'(dp10), 32'(m_dp));
      chk("rnd_pos10", 32'(pos10), 32'(m_p10));
      if ($urandom_range(0, 99) == 0) run = ~run;
      if ($urandom_range(0, 79) == 0) U_D = ~U_D;
      home  = ($urandom_range(0, 149) == 0);
      dp_in = 1'($urandom_range(0, 1));
      if (sys_rst) sys_rst = 1'b0;
      else if ($urandom_range(0, 799) == 0) sys_rst = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
